ex_flag_stage: RTL
==================

Name: ex_flag_stage

Overview:
- Execute-stage consumer of the ALU-control/flag-enable pipeline register.
- Takes the registered 3-bit ALU control and flag-enable, plus ALU result flags, and owns the architectural NZCV register.
- Forwards flags to the B.cond evaluator, including same-cycle bypass.
- Registers a valid/control bundle into the EX/MEM boundary.
- Supports stall and flush from the hazard unit.

Parameters:
- NFLAG, 4, flag vector width, ordered {N,Z,C,V}.
- CW, 3, ALU control width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  EX slot holds a real instruction.
- alu_cntrl  input  CW  registered ALU control from the upstream queue.
- flag_en  input  1  registered flag-enable from the upstream queue.
- alu_neg, alu_zero, alu_carry, alu_ovf  input  1 each  ALU result flags for the current EX instruction.
- stall  input  1  hold EX/MEM outputs and flag register.
- flush  input  1  kill the current EX instruction.
- cond_valid  input  1  decode requests a B.cond evaluation this cycle.
- cond  input  4  ARM condition code: 0000 EQ … 1101 LE, 1110 AL.
- cond_taken  output  1  combinational branch decision.
- flags_q  output  NFLAG  architectural NZCV register.
- mem_valid  output  1  registered valid to MEM.
- mem_alu_cntrl  output  CW  registered ALU control to MEM.
- flag_writes  output  8  wrapping count of committed flag updates, for debug.

Behaviour:
- Reset (reset==0, async): flags_q=4'b0000, mem_valid=0, mem_alu_cntrl=3'b000, flag_writes=0. Release is sampled on the next rising edge.
- commit = in_valid & ~flush & ~stall.
- Flag write: on posedge, if commit & flag_en, flags_q <= {alu_neg,alu_zero,alu_carry,alu_ovf} and flag_writes increments mod 256. Otherwise both hold.
- flag_en with in_valid=0 never writes.
- Flush wins over everything: no flag write, no count.
- Stall with flush: flush dominates the valid (mem_valid <= 0); flags still hold.
- EX/MEM register, on posedge:
  - stall=1 & flush=0: mem_valid and mem_alu_cntrl hold.
  - flush=1: mem_valid <= 0, mem_alu_cntrl <= 000.
  - Otherwise: mem_valid <= in_valid, mem_alu_cntrl <= alu_cntrl.
- Latency: 1 cycle from input to mem_* and to flags_q.
- Flag source for cond_taken (combinational):
  - eff_flags = new ALU flags if (in_valid & flag_en & ~flush), else flags_q.
  - Bypass is independent of stall: a stalled flag-setter still forwards its flags.
- cond_taken = cond_valid & eval(cond, eff_flags):
  - EQ: Z. NE: !Z.
  - CS: C. CC: !C.
  - MI: N. PL: !N.
  - VS: V. VC: !V.
  - HI: C&!Z. LS: !C|Z.
  - GE: N==V. LT: N!=V.
  - GT: !Z&(N==V). LE: Z|(N!=V).
  - AL: 1. 1111: 0 (reserved).
- cond_valid=0 forces cond_taken=0.
- Simultaneous flag write and B.cond evaluation in the same cycle: the bypassed (new) flags are used.
- flag_writes wraps from 255 to 0 with no flag output.
- Reset asserted mid-operation clears all state immediately. Outputs are reset values while reset==0.

Decomposition:
- Shared package cpu_pkg:
  - cond_e enum (4-bit ARM codes).
  - alu_op_e enum: 000 PASSB, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_eval: pure combinational cond + flags -> taken.
- Flag register and EX/MEM register stay in this block, built from per-bit D_FF with an enable mux.

Test Plan:
- Reset: hold reset=0 two cycles with random inputs -> flags_q=0000, mem_valid=0, mem_alu_cntrl=000, flag_writes=0. Release -> values unchanged until the first commit.
- Flag write: in_valid=1, flag_en=1, alu_cntrl=011, flags N0 Z1 C1 V0 -> next cycle flags_q=0110, mem_alu_cntrl=011, flag_writes=1. Same with flag_en=0 and flags 1001 -> flags_q stays 0110.
- Bypass: flags_q=0000; flag-setter with Z=1 plus cond_valid=1, cond=EQ in the same cycle -> cond_taken=1 that cycle. Next cycle, flags_q=0100 and cond NE -> cond_taken=0.
- Condition sweep: for flags_q in {0000,1000,0001,1001,0110,0010}, all 16 conds -> cond_taken matches the table; 1111 is always 0 and AL is always 1.
- Stall/flush:
  - stall=1 with a flag-setter -> flags_q and mem_* unchanged, bypass still active.
  - flush=1 with a flag-setter -> no write, mem_valid=0, cond_taken uses flags_q.
  - stall and flush together -> mem_valid=0.
- Async reset and wrap: 256 committed flag writes -> flag_writes back to 0. Assert reset between clock edges mid-stream -> outputs clear without waiting for an edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the execute-stage flag logic:
//                ARM condition codes, ALU operation codes, NZCV bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition codes carried by B.cond
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // ALU control encodings travelling down the pipe
  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110
  } alu_op_e;

  // Assemble the individual ALU result flags into NZCV order
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Pure combinational ARM condition evaluator. Maps a 4-bit
//                condition code and an NZCV vector to a taken decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags_i[FLAG_N];
  assign w_z = flags_i[FLAG_Z];
  assign w_c = flags_i[FLAG_C];
  assign w_v = flags_i[FLAG_V];

  // Decode the condition against the flag vector; NV (1111) is reserved and never taken
  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: taken_o = w_z;
      COND_NE: taken_o = ~w_z;
      COND_CS: taken_o = w_c;
      COND_CC: taken_o = ~w_c;
      COND_MI: taken_o = w_n;
      COND_PL: taken_o = ~w_n;
      COND_VS: taken_o = w_v;
      COND_VC: taken_o = ~w_v;
      COND_HI: taken_o = w_c & ~w_z;
      COND_LS: taken_o = ~w_c | w_z;
      COND_GE: taken_o = (w_n == w_v);
      COND_LT: taken_o = (w_n != w_v);
      COND_GT: taken_o = ~w_z & (w_n == w_v);
      COND_LE: taken_o = w_z | (w_n != w_v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_flag_stage
//  Description : Execute-stage owner of the architectural NZCV register.
//                Commits ALU flags under flag-enable, bypasses in-flight
//                flags to the B.cond evaluator, and registers the valid /
//                ALU-control bundle into the EX/MEM boundary with
//                stall and flush support.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_flag_stage
  import cpu_pkg::*;
#(
  parameter int NFLAG = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CW-1:0]    alu_cntrl,
  input  logic             flag_en,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             stall,
  input  logic             flush,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             cond_taken,
  output logic [NFLAG-1:0] flags_q,
  output logic             mem_valid,
  output logic [CW-1:0]    mem_alu_cntrl,
  output logic [7:0]       flag_writes
);

  logic [NFLAG-1:0] w_alu_flags;
  logic [NFLAG-1:0] w_eff_flags;
  logic [NFLAG-1:0] flags_d;
  logic [NFLAG-1:0] flag_reg_q;
  logic             w_commit;
  logic             w_flag_we;
  logic             w_bypass;
  logic             w_taken;

  logic             mem_valid_d;
  logic             mem_valid_q;
  logic [CW-1:0]    mem_cntrl_d;
  logic [CW-1:0]    mem_cntrl_q;
  logic [7:0]       flag_writes_d;
  logic [7:0]       flag_writes_q;

  assign w_alu_flags = pack_flags(alu_neg, alu_zero, alu_carry, alu_ovf);

  // An instruction retires from EX only when it is real, not killed and not held
  assign w_commit  = in_valid & ~flush & ~stall;
  assign w_flag_we = w_commit & flag_en;

  // A stalled flag-setter still forwards its flags; only a flush suppresses the bypass
  assign w_bypass    = in_valid & flag_en & ~flush;
  assign w_eff_flags = w_bypass ? w_alu_flags : flag_reg_q;

  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (w_eff_flags),
    .taken_o (w_taken)
  );

  assign cond_taken = cond_valid & w_taken;

  // Enable muxes in front of the flag and EX/MEM flops; flush takes priority over stall
  always_comb begin
    flags_d       = w_flag_we ? w_alu_flags : flag_reg_q;
    flag_writes_d = w_flag_we ? (flag_writes_q + 8'd1) : flag_writes_q;
    mem_valid_d   = mem_valid_q;
    mem_cntrl_d   = mem_cntrl_q;
    if (flush) begin
      mem_valid_d = 1'b0;
      mem_cntrl_d = '0;
    end else if (!stall) begin
      mem_valid_d = in_valid;
      mem_cntrl_d = alu_cntrl;
    end
  end

  // One D flop per NZCV bit
  for (genvar i = 0; i < NFLAG; i++) begin : g_flag_bit
    // Architectural flag bit i
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) flag_reg_q[i] <= 1'b0;
      else        flag_reg_q[i] <= flags_d[i];
    end
  end

  // One D flop per ALU-control bit of the EX/MEM boundary
  for (genvar j = 0; j < CW; j++) begin : g_cntrl_bit
    // EX/MEM ALU-control bit j
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_cntrl_q[j] <= 1'b0;
      else        mem_cntrl_q[j] <= mem_cntrl_d[j];
    end
  end

  // EX/MEM valid bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_valid_q <= 1'b0;
    else        mem_valid_q <= mem_valid_d;
  end

  // Debug count of committed flag updates, wraps modulo 256
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flag_writes_q <= 8'd0;
    else        flag_writes_q <= flag_writes_d;
  end

  assign flags_q       = flag_reg_q;
  assign mem_valid     = mem_valid_q;
  assign mem_alu_cntrl = mem_cntrl_q;
  assign flag_writes   = flag_writes_q;

endmodule
`default_nettype wire
